// File: rtl/ds1302_seq.sv
// DS1302 transaction sequencer: periodic 7-register refresh into shadow registers plus host writes.
// Define DS1302_SEQ_WP_EN to bracket each host write with write-protect clear/set transactions.
module ds1302_seq #(
   parameter int REFRESH_CYCLES = 1000000,
   parameter int CNT_W          = 20
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        wr_req,
   input  logic [2:0]  wr_idx,
   input  logic [7:0]  wr_data,
   output logic        wr_ack,
   output logic        wr_err,
   // `time` is a reserved word, so the shadow register bank is exported as time_out.
   output logic [55:0] time_out,
   output logic        time_valid,
   output logic        busy,
   output logic        eng_ena,
   output logic [7:0]  eng_addr,
   output logic [7:0]  eng_w,
   input  logic [7:0]  eng_r,
   input  logic        eng_ready,
   input  logic        eng_done
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

`ifdef DS1302_SEQ_WP_EN
   typedef enum logic [3:0] {
      S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT, S_ACK,
      S_WPC_ISSUE, S_WPC_WAIT, S_WPS_ISSUE, S_WPS_WAIT
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_WR_WAIT, S_ACK
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pending_q, pending_d;
   logic [55:0]        time_q, time_d;
   logic               wr_ack_q, wr_ack_d;
   logic               wr_err_q, wr_err_d;
   logic               time_valid_q, time_valid_d;
   logic               busy_q, busy_d;
   logic               eng_ena_q, eng_ena_d;
   logic [7:0]         eng_addr_q, eng_addr_d;
   logic [7:0]         eng_w_q, eng_w_d;
   logic               wrap, pending_set, pending_clr;
   logic [2:0]         idx_next;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      data_d       = data_q;
      time_d       = time_q;
      eng_ena_d    = eng_ena_q;
      eng_addr_d   = eng_addr_q;
      eng_w_d      = eng_w_q;
      wr_ack_d     = 1'b0;
      wr_err_d     = 1'b0;
      time_valid_d = 1'b0;
      pending_clr  = 1'b0;
      idx_next     = idx_q + 3'd1;
      wrap         = (cnt_q == CNT_MAX);
      cnt_d        = wrap ? '0 : cnt_q + 1'b1;
      pending_set  = wrap;

      case (state_q)
         S_IDLE: begin
            if (wr_req && (wr_idx == 3'd7)) begin
               wr_ack_d = 1'b1;
               wr_err_d = 1'b1;
               state_d  = S_ACK;
            end else if (wr_req) begin
               idx_d     = wr_idx;
               data_d    = wr_data;
               eng_ena_d = 1'b1;
`ifdef DS1302_SEQ_WP_EN
               eng_addr_d = 8'h8E;
               eng_w_d    = 8'h00;
               state_d    = S_WPC_ISSUE;
`else
               eng_addr_d = {4'h8, wr_idx, 1'b0};
               eng_w_d    = wr_data;
               state_d    = S_WR_ISSUE;
`endif
            end else if (pending_q) begin
               pending_clr = 1'b1;
               idx_d       = 3'd0;
               eng_ena_d   = 1'b1;
               eng_addr_d  = 8'h81;
               eng_w_d     = 8'h00;
               state_d     = S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: begin
            if (eng_ready) begin
               eng_ena_d = 1'b0;
               state_d   = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (eng_done) begin
               for (int i = 0; i < 7; i++) begin
                  if (idx_q == 3'(i)) time_d[i*8 +: 8] = eng_r;
               end
               if (idx_q == 3'd6) begin
                  time_valid_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  idx_d      = idx_next;
                  eng_ena_d  = 1'b1;
                  eng_addr_d = {4'h8, idx_next, 1'b1};
                  state_d    = S_RD_ISSUE;
               end
            end
         end
`ifdef DS1302_SEQ_WP_EN
         S_WPC_ISSUE: begin
            if (eng_ready) begin
               eng_ena_d = 1'b0;
               state_d   = S_WPC_WAIT;
            end
         end
         S_WPC_WAIT: begin
            if (eng_done) begin
               eng_ena_d  = 1'b1;
               eng_addr_d = {4'h8, idx_q, 1'b0};
               eng_w_d    = data_q;
               state_d    = S_WR_ISSUE;
            end
         end
         S_WPS_ISSUE: begin
            if (eng_ready) begin
               eng_ena_d = 1'b0;
               state_d   = S_WPS_WAIT;
            end
         end
         S_WPS_WAIT: begin
            if (eng_done) begin
               wr_ack_d    = 1'b1;
               pending_set = 1'b1;
               state_d     = S_ACK;
            end
         end
`endif
         S_WR_ISSUE: begin
            if (eng_ready) begin
               eng_ena_d = 1'b0;
               state_d   = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (eng_done) begin
`ifdef DS1302_SEQ_WP_EN
               eng_ena_d  = 1'b1;
               eng_addr_d = 8'h8E;
               eng_w_d    = 8'h80;
               state_d    = S_WPS_ISSUE;
`else
               wr_ack_d    = 1'b1;
               pending_set = 1'b1;
               state_d     = S_ACK;
`endif
            end
         end
         // One cycle holding wr_ack so the host can drop wr_req before IDLE looks again.
         S_ACK: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      pending_d = pending_set ? 1'b1 : (pending_clr ? 1'b0 : pending_q);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= S_IDLE;
         idx_q        <= 3'd0;
         data_q       <= 8'h00;
         cnt_q        <= '0;
         pending_q    <= 1'b1;
         time_q       <= 56'd0;
         wr_ack_q     <= 1'b0;
         wr_err_q     <= 1'b0;
         time_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         eng_ena_q    <= 1'b0;
         eng_addr_q   <= 8'h00;
         eng_w_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         time_q       <= time_d;
         wr_ack_q     <= wr_ack_d;
         wr_err_q     <= wr_err_d;
         time_valid_q <= time_valid_d;
         busy_q       <= busy_d;
         eng_ena_q    <= eng_ena_d;
         eng_addr_q   <= eng_addr_d;
         eng_w_q      <= eng_w_d;
      end
   end

   assign wr_ack     = wr_ack_q;
   assign wr_err     = wr_err_q;
   assign time_out   = time_q;
   assign time_valid = time_valid_q;
   assign busy       = busy_q;
   assign eng_ena    = eng_ena_q;
   assign eng_addr   = eng_addr_q;
   assign eng_w      = eng_w_q;

endmodule

// File: tb/tb_ds1302_seq.sv
// Bench for ds1302_seq: DS1302 register model behind a handshake engine, expected transaction
// queue and expected shadow-register image derived from the register map.
`timescale 1ns/1ps
module tb_ds1302_seq;

   localparam int REFRESH = 64;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        wr_req = 1'b0;
   logic [2:0]  wr_idx = 3'd0;
   logic [7:0]  wr_data = 8'h00;
   logic        wr_ack, wr_err, time_valid, busy, eng_ena;
   logic [55:0] time_out;
   logic [7:0]  eng_addr, eng_w;
   logic [7:0]  eng_r = 8'h00;
   logic        eng_ready = 1'b1;
   logic        eng_done = 1'b0;

   ds1302_seq #(.REFRESH_CYCLES(REFRESH), .CNT_W(8)) dut (
      .clk(clk), .clrn(clrn), .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err), .time_out(time_out), .time_valid(time_valid),
      .busy(busy), .eng_ena(eng_ena), .eng_addr(eng_addr), .eng_w(eng_w),
      .eng_r(eng_r), .eng_ready(eng_ready), .eng_done(eng_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          fails = 0;
   int          tv_cnt = 0;
   int          cyc = 0;
   int          lat = 0;
   bit          acc = 1'b0;
   bit          hold_low = 1'b0;
   logic [7:0]  rd_val = 8'h00;
   logic [7:0]  rtc_mem [0:6];
   logic [7:0]  ref_regs [0:6];
   logic [15:0] obs_q[$];
   int          obs_tv_q[$];
   int          burst_cyc_q[$];
   logic [15:0] exp_q[$];

   // Engine + DS1302 model, acting on the falling edge so the DUT samples stable inputs.
   always @(negedge clk) begin
      cyc++;
      if (!clrn) begin
         acc = 1'b0;
         lat = 0;
         eng_done = 1'b0;
         eng_ready = !hold_low;
      end else begin
         if (time_valid) tv_cnt++;
         eng_done = 1'b0;
         if (acc) begin
            acc = 1'b0;
            lat = $urandom_range(1, 3);
         end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
               eng_done = 1'b1;
               eng_r = rd_val;
            end
         end
         eng_ready = (lat == 0) && !acc && !hold_low;
         if (eng_ena && eng_ready) begin
            acc = 1'b1;
            obs_q.push_back({eng_addr, eng_w});
            obs_tv_q.push_back(tv_cnt);
            if (eng_addr == 8'h81) burst_cyc_q.push_back(cyc);
            if (eng_addr[7:4] == 4'h8 && eng_addr[3:1] != 3'd7) begin
               if (eng_addr[0]) rd_val = rtc_mem[eng_addr[3:1]];
               else rtc_mem[eng_addr[3:1]] = eng_w;
            end else begin
               rd_val = 8'hFF;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mask_rd(input logic [15:0] t);
      return t[8] ? {t[15:8], 8'h00} : t;
   endfunction

   function automatic logic [55:0] ref_time();
      logic [55:0] t;
      for (int i = 0; i < 7; i++) t[i*8 +: 8] = ref_regs[i];
      return t;
   endfunction

   task automatic push_burst();
      for (int i = 0; i < 7; i++) exp_q.push_back({8'(8'h81 + 2*i), 8'h00});
   endtask

   task automatic push_write(input logic [2:0] idx, input logic [7:0] data);
`ifdef DS1302_SEQ_WP_EN
      exp_q.push_back(16'h8E00);
`endif
      exp_q.push_back({8'(8'h80 + 2*int'(idx)), data});
`ifdef DS1302_SEQ_WP_EN
      exp_q.push_back(16'h8E80);
`endif
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_len"}, 64'(obs_q.size() >= exp_q.size()), 64'd1);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs_q.size())
            chk($sformatf("%s_txn%0d", tag, i), 64'(mask_rd(obs_q[i])), 64'(mask_rd(exp_q[i])));
      end
   endtask

   task automatic wait_tv(input int target, input string tag);
      int k = 0;
      while (tv_cnt < target && k < 400) begin step(); k++; end
      chk({tag, "_tv_seen"}, 64'(tv_cnt >= target), 64'd1);
   endtask

   task automatic wait_obs(input int n, input string tag);
      int k = 0;
      while (obs_q.size() < n && k < 400) begin step(); k++; end
      chk({tag, "_txn_seen"}, 64'(obs_q.size() >= n), 64'd1);
   endtask

   task automatic sync_tv();
      wait_tv(tv_cnt + 1, "sync");
      obs_q.delete();
      obs_tv_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_ack(input string tag, output logic err);
      int k = 0;
      while (wr_ack !== 1'b1 && k < 400) begin step(); k++; end
      chk({tag, "_ack_seen"}, 64'(wr_ack), 64'd1);
      err = wr_err;
      wr_req = 1'b0;
      step();
      chk({tag, "_ack_pulse"}, 64'(wr_ack), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
      chk({tag, "_wr_err"}, 64'(wr_err), 64'd0);
      chk({tag, "_time"}, 64'(time_out), 64'd0);
      chk({tag, "_time_valid"}, 64'(time_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_eng_ena"}, 64'(eng_ena), 64'd0);
      chk({tag, "_eng_addr"}, 64'(eng_addr), 64'd0);
      chk({tag, "_eng_w"}, 64'(eng_w), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] idx;
      logic [7:0] data;
      logic       err;
      int         tv0, nw;

      for (int i = 0; i < 7; i++) begin
         rtc_mem[i]  = 8'(8'h81 + 2*i) ^ 8'h5A;
         ref_regs[i] = 8'(8'h81 + 2*i) ^ 8'h5A;
      end

      // Reset values, then the first refresh burst after release.
      repeat (3) step();
      check_idle_outputs("reset");
      clrn = 1'b1;
      push_burst();
      wait_tv(1, "burst1");
      chk("burst1_single_tv", 64'(tv_cnt), 64'd1);
      check_log("burst1");
      chk("burst1_time", 64'(time_out), 64'h00D7D1D3DDDFD9DB);
      begin
         int k = 0;
         while (burst_cyc_q.size() < 2 && k < 400) begin step(); k++; end
         chk("burst_period_seen", 64'(burst_cyc_q.size() >= 2), 64'd1);
         if (burst_cyc_q.size() >= 2)
            chk("burst_period", 64'(burst_cyc_q[1] - burst_cyc_q[0]), 64'(REFRESH));
      end

      // Host writes: the fixed case first, then random indices and data.
      for (int n = 0; n < 4; n++) begin
         sync_tv();
         idx  = (n == 0) ? 3'd2 : 3'($urandom_range(0, 6));
         data = (n == 0) ? 8'h23 : 8'($urandom);
         push_write(idx, data);
         push_burst();
         ref_regs[idx] = data;
         tv0 = tv_cnt;
         wr_idx = idx; wr_data = data; wr_req = 1'b1;
         wait_ack($sformatf("wr%0d", n), err);
         chk($sformatf("wr%0d_err", n), 64'(err), 64'd0);
         wait_tv(tv0 + 1, $sformatf("wr%0d_refresh", n));
         check_log($sformatf("wr%0d", n));
         chk($sformatf("wr%0d_time", n), 64'(time_out), 64'(ref_time()));
      end

      // Illegal index: immediate ack with error, no engine traffic.
      sync_tv();
      wr_idx = 3'd7; wr_data = 8'($urandom); wr_req = 1'b1;
      step();
      chk("illegal_ack", 64'(wr_ack), 64'd1);
      chk("illegal_err", 64'(wr_err), 64'd1);
      chk("illegal_eng_ena", 64'(eng_ena), 64'd0);
      wr_req = 1'b0;
      step();
      chk("illegal_ack_pulse", 64'(wr_ack), 64'd0);
      repeat (3) step();
      chk("illegal_no_traffic", 64'(obs_q.size()), 64'd0);

      // Request raised during the third read of a burst waits for the burst to finish.
      sync_tv();
      wait_obs(3, "midburst");
      idx = 3'($urandom_range(0, 6)); data = 8'($urandom);
      tv0 = tv_cnt;
      push_burst();
      push_write(idx, data);
      nw = exp_q.size() - 7;
      push_burst();
      ref_regs[idx] = data;
      wr_idx = idx; wr_data = data; wr_req = 1'b1;
      wait_ack("midburst", err);
      wait_tv(tv0 + 2, "midburst_refresh");
      check_log("midburst");
      if (obs_tv_q.size() > 7)
         chk("midburst_tv_before_write", 64'(obs_tv_q[7]), 64'(tv0 + 1));
      chk("midburst_time", 64'(time_out), 64'(ref_time()));

      // eng_ready held low while in ISSUE: eng_ena holds, one transaction results.
      sync_tv();
      hold_low = 1'b1;
      step();
      idx = 3'($urandom_range(0, 6)); data = 8'($urandom);
      push_write(idx, data);
      push_burst();
      ref_regs[idx] = data;
      tv0 = tv_cnt;
      wr_idx = idx; wr_data = data; wr_req = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_ena%0d", i), 64'(eng_ena), 64'd1);
         step();
      end
      chk("stall_no_accept", 64'(obs_q.size()), 64'd0);
      hold_low = 1'b0;
      wait_ack("stall", err);
      wait_tv(tv0 + 1, "stall_refresh");
      check_log("stall");
      chk("stall_time", 64'(time_out), 64'(ref_time()));

      // Reset while waiting on a write transaction.
      sync_tv();
      wr_idx = 3'd1; wr_data = ref_regs[1]; wr_req = 1'b1;
      wait_obs(1, "rstwait");
      step();
      #1;
      clrn = 1'b0;
      wr_req = 1'b0;
      #1;
      check_idle_outputs("rstwait");
      step();
      step();
      obs_q.delete();
      clrn = 1'b1;
      tv0 = tv_cnt;
      wait_obs(1, "rstwait_after");
      if (obs_q.size() > 0) chk("rstwait_first_addr", 64'(obs_q[0][15:8]), 64'h81);
      wait_tv(tv0 + 1, "rstwait_refresh");
      chk("rstwait_time", 64'(time_out), 64'(ref_time()));

      // Write request and pending refresh in the same IDLE cycle right after reset.
      step();
      clrn = 1'b0;
      idx = 3'($urandom_range(0, 6)); data = 8'($urandom);
      wr_idx = idx; wr_data = data; wr_req = 1'b1;
      step();
      step();
      obs_q.delete();
      exp_q.delete();
      push_write(idx, data);
      push_burst();
      ref_regs[idx] = data;
      tv0 = tv_cnt;
      clrn = 1'b1;
      wait_ack("both", err);
      chk("both_err", 64'(err), 64'd0);
      wait_tv(tv0 + 1, "both_refresh");
      chk("both_one_burst", 64'(obs_q.size()), 64'(exp_q.size()));
      check_log("both");
      chk("both_time", 64'(time_out), 64'(ref_time()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule

// File: doc/ds1302_seq.md
# ds1302_seq

Transaction sequencer for the DS1302 single-byte engine. It periodically reads the seven timekeeping registers into shadow registers and serves host write requests. Write requests are optionally bracketed by write-protect clear/set transactions. It is the only master of the byte engine and sits between the engine and the system register interface.

## Interface
Parameters:
- REFRESH_CYCLES, 1000000: clk cycles between refresh bursts; legal range 2..2^CNT_W.
- CNT_W, 20: refresh counter width.

Ports:
- clk  in  1  clock.
- clrn  in  1  asynchronous, active-low reset.
- wr_req  in  1  host write request, level; hold with wr_idx/wr_data until wr_ack.
- wr_idx  in  3  register index: 0 sec, 1 min, 2 hour, 3 date, 4 month, 5 day, 6 year; 7 illegal.
- wr_data  in  8  raw BCD byte to write.
- wr_ack  out  1  one-cycle pulse; request finished.
- wr_err  out  1  valid with wr_ack; 1 = wr_idx was 7 and nothing was written.
- time  out  56  shadow registers, {year,day,month,date,hour,min,sec}, raw bytes.
- time_valid  out  1  one-cycle pulse after a refresh burst completes.
- busy  out  1  high whenever the FSM is not in IDLE.
- eng_ena  out  1  engine start strobe.
- eng_addr  out  8  engine command byte; bit0 = 1 means read.
- eng_w  out  8  engine write byte.
- eng_r  in  8  engine read byte; valid in the eng_done cycle.
- eng_ready  in  1  engine idle; it accepts eng_ena only while this is high.
- eng_done  in  1  one-cycle pulse at the end of each transaction.

Reset values: all outputs are 0. time is 0. The FSM is in IDLE, refresh_pending = 1, and the counter is 0.

## Operation
- Refresh counter: free-running from 0 to REFRESH_CYCLES-1. On wrap it sets refresh_pending. It keeps counting during bursts.
- IDLE arbitration, evaluated each cycle:
  - wr_req with wr_idx = 7: pulse wr_ack and wr_err on the next cycle, with no engine traffic.
  - Legal wr_req: latch wr_idx/wr_data and start the write sequence.
  - Otherwise, refresh_pending: clear it and start the refresh burst.
  - Write has priority when both are present in the same cycle.
- Each engine transaction uses two states:
  - ISSUE: drive eng_ena = 1 with eng_addr/eng_w. Advance when eng_ready = 1 at the edge; otherwise hold.
  - WAIT: eng_ena = 0. Advance on eng_done.
- Refresh burst: 7 reads at addresses 0x81, 0x83, 0x85, 0x87, 0x89, 0x8B, 0x8D, in index order. On each eng_done, eng_r is written into byte[idx] of time. time_valid pulses the cycle after the 7th capture, and the FSM returns to IDLE.
- Write sequence: WP_CLR writes 0x8E/0x00, then WR writes (0x80 + 2*idx)/wr_data, then WP_SET writes 0x8E/0x80.
  - After the final done: wr_ack pulses, refresh_pending is set so the shadow registers get updated, and the FSM returns to IDLE.
- A wr_req arriving during a burst waits in IDLE until the burst ends. Bursts are never preempted.
- A refresh wrap during a write only sets refresh_pending. Multiple wraps collapse into one pending refresh.
- The shadow registers change only on read captures. Writes never modify them directly.
- Reset mid-operation: everything returns to its reset values immediately. The engine shares clrn. No partial write-protect state is tracked.

## Timing
- ISSUE→WAIT takes 1 cycle when eng_ready is high.
- Per transaction overhead is 1 cycle in ISSUE plus the engine latency.
- time_valid rises 1 cycle after the last eng_done. wr_ack rises 1 cycle after the last eng_done.
- Minimum IDLE dwell between sequences is 1 cycle.
- eng_addr and eng_w are registered and stable for the whole transaction.

## Configuration
- DS1302_SEQ_WP_EN defined: the write sequence is WP_CLR, WR, WP_SET, i.e. 3 engine transactions per write.
- Not defined: the write sequence is WR only, 1 transaction. The WP states are absent and 0x8E is never addressed.

## Test plan
- Reset release with REFRESH_CYCLES = 64 and an engine model returning addr^0x5A:
  - 7 reads occur at 0x81 through 0x8D in order.
  - time = {0xD7,0xD1,0xD3,0xDD,0xDF,0xD9,0xDB}; time_valid is a single pulse.
  - The next burst starts 64 cycles after the previous one.
- wr_req with idx = 2 and data = 0x23, WP_EN defined:
  - Engine sees 0x8E/0x00, then 0x84/0x23, then 0x8E/0x80.
  - wr_ack is one pulse with wr_err = 0, followed by a refresh burst.
- Same request with WP_EN undefined: the only write is 0x84/0x23, then wr_ack, then a refresh.
- wr_req with idx = 7: wr_ack = wr_err = 1 on the next cycle, and eng_ena stays 0.
- wr_req and refresh_pending in the same IDLE cycle: the write sequence runs first, then exactly one burst.
- wr_req raised during the 3rd burst read: the burst completes fully and time_valid pulses before the first write transaction is issued.
- clrn asserted while in WAIT of a write: all outputs are 0 immediately. After release, the first action is a refresh burst.
- eng_ready held low for 5 cycles in ISSUE: eng_ena stays high until eng_ready rises, and exactly one transaction results.
